// File: rtl/ysyx_25020037_mem_arbiter_pkg.sv
// Shared encodings for the I/D memory-port arbiter.
package ysyx_25020037_pkg;

    // Arbiter FSM state encoding
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } state_t;

    // Requester identifiers used by the last-grant register
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/ysyx_25020037_rr_arb2.sv
// Two-input round-robin pick with a last-grant register; only picks when enabled.
module ysyx_25020037_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_i,
    input  logic req_d,
    output logic gnt_i_c,
    output logic gnt_d_c
);
    import ysyx_25020037_pkg::*;

    logic last_grant;

    // On a tie the side that did not win last time is picked
    always_comb begin
        gnt_i_c = en && req_i && (!req_d || (last_grant == REQ_D));
        gnt_d_c = en && req_d && (!req_i || (last_grant == REQ_I));
    end

    // Remember the winner; reset favours I on the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= REQ_D;
        end else if (gnt_i_c) begin
            last_grant <= REQ_I;
        end else if (gnt_d_c) begin
            last_grant <= REQ_D;
        end
    end

endmodule

// File: rtl/ysyx_25020037_mem_arbiter.sv
// Shares the core memory port between icache refill (I) and LSU (D); one outstanding transaction.
module ysyx_25020037_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    output logic [DATA_WIDTH-1:0]     i_rdata,
    output logic                      i_ready,
    output logic                      i_err,
    input  logic                      d_req,
    input  logic [ADDR_WIDTH-1:0]     d_addr,
    input  logic                      d_wen,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    input  logic [DATA_WIDTH/8-1:0]   d_wmask,
    output logic [DATA_WIDTH-1:0]     d_rdata,
    output logic                      d_ready,
    output logic                      d_err,
    output logic                      m_req,
    output logic [ADDR_WIDTH-1:0]     m_addr,
    output logic                      m_wen,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wmask,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic                      m_ready
);
    import ysyx_25020037_pkg::*;

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             gnt_i_c;
    logic             gnt_d_c;
    logic             timeout_hit_c;
    logic             in_gi_c;
    logic             in_gd_c;

    ysyx_25020037_rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .en      (state == IDLE),
        .req_i   (i_req),
        .req_d   (d_req),
        .gnt_i_c (gnt_i_c),
        .gnt_d_c (gnt_d_c)
    );

    // Timeout fires on the last allowed grant cycle unless m_ready arrives with it
    always_comb begin
        in_gi_c       = (state == GRANT_I);
        in_gd_c       = (state == GRANT_D);
        timeout_hit_c = (TIMEOUT != 0) && (in_gi_c || in_gd_c) && !m_ready
                        && (cnt == CNT_W'(TIMEOUT - 1));
    end

    // Combinational response steering to the granted side only
    always_comb begin
        i_ready = in_gi_c && (m_ready || timeout_hit_c);
        i_err   = in_gi_c && timeout_hit_c;
        i_rdata = (in_gi_c && m_ready) ? m_rdata : '0;
        d_ready = in_gd_c && (m_ready || timeout_hit_c);
        d_err   = in_gd_c && timeout_hit_c;
        d_rdata = (in_gd_c && m_ready) ? m_rdata : '0;
    end

    // FSM, timeout counter and registered downstream request path
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            m_req   <= 1'b0;
            m_addr  <= '0;
            m_wen   <= 1'b0;
            m_wdata <= '0;
            m_wmask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_i_c) begin
                        state   <= GRANT_I;
                        cnt     <= '0;
                        m_req   <= 1'b1;
                        m_addr  <= i_addr;
                        m_wen   <= 1'b0;
                        m_wdata <= '0;
                        m_wmask <= STRB_W'(0);
                    end else if (gnt_d_c) begin
                        state   <= GRANT_D;
                        cnt     <= '0;
                        m_req   <= 1'b1;
                        m_addr  <= d_addr;
                        m_wen   <= d_wen;
                        m_wdata <= d_wdata;
                        m_wmask <= d_wmask;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (m_ready || timeout_hit_c) begin
                        state <= IDLE;
                        cnt   <= '0;
                        m_req <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_mem_arbiter.sv
// Directed bench for the I/D memory arbiter with hand-computed expectations.
module tb_ysyx_25020037_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic [DW-1:0]   i_rdata;
    logic            i_ready;
    logic            i_err;
    logic            d_req;
    logic [AW-1:0]   d_addr;
    logic            d_wen;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_wmask;
    logic [DW-1:0]   d_rdata;
    logic            d_ready;
    logic            d_err;
    logic            m_req;
    logic [AW-1:0]   m_addr;
    logic            m_wen;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wmask;
    logic [DW-1:0]   m_rdata;
    logic            m_ready;

    int checks   = 0;
    int failures = 0;

    ysyx_25020037_mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ready (i_ready),
        .i_err   (i_err),
        .d_req   (d_req),
        .d_addr  (d_addr),
        .d_wen   (d_wen),
        .d_wdata (d_wdata),
        .d_wmask (d_wmask),
        .d_rdata (d_rdata),
        .d_ready (d_ready),
        .d_err   (d_err),
        .m_req   (m_req),
        .m_addr  (m_addr),
        .m_wen   (m_wen),
        .m_wdata (m_wdata),
        .m_wmask (m_wmask),
        .m_rdata (m_rdata),
        .m_ready (m_ready)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs
    task automatic settle();
        #1;
    endtask

    logic exp_side [4];

    initial begin
        exp_side = '{1'b0, 1'b1, 1'b0, 1'b1};
        rst = 1'b0; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_addr = '0; d_wen = 1'b0; d_wdata = '0; d_wmask = '0;
        m_rdata = '0; m_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_m_req", 32'(m_req), 32'h0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_wen", 32'(m_wen), 32'h0);
        chk("rst_i_ready", 32'(i_ready), 32'h0);
        chk("rst_d_ready", 32'(d_ready), 32'h0);
        cyc(); cyc();
        rst = 1'b1;
        settle();

        // Single I read, m_ready three cycles after m_req
        i_addr = 32'h8000_0010; i_req = 1'b1;
        settle();
        chk("i_latency", 32'(m_req), 32'h0);
        cyc(); settle();
        chk("i_m_req", 32'(m_req), 32'h1);
        chk("i_m_addr", m_addr, 32'h8000_0010);
        chk("i_m_wen", 32'(m_wen), 32'h0);
        chk("i_m_wmask", 32'(m_wmask), 32'h0);
        chk("i_early_ready", 32'(i_ready), 32'h0);
        cyc(); cyc(); cyc();
        m_ready = 1'b1; m_rdata = 32'h0000_0513;
        settle();
        chk("i_ready", 32'(i_ready), 32'h1);
        chk("i_rdata", i_rdata, 32'h0000_0513);
        chk("i_err", 32'(i_err), 32'h0);
        chk("i_d_ready", 32'(d_ready), 32'h0);
        cyc();
        i_req = 1'b0; m_ready = 1'b0;
        settle();
        chk("i_done_m_req", 32'(m_req), 32'h0);
        chk("i_done_ready", 32'(i_ready), 32'h0);

        // D write
        d_addr = 32'h8000_1000; d_wen = 1'b1; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011;
        d_req = 1'b1;
        settle();
        cyc(); settle();
        chk("d_m_req", 32'(m_req), 32'h1);
        chk("d_m_addr", m_addr, 32'h8000_1000);
        chk("d_m_wen", 32'(m_wen), 32'h1);
        chk("d_m_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("d_m_wmask", 32'(m_wmask), 32'h3);
        m_ready = 1'b1; m_rdata = 32'h1111_1111;
        settle();
        chk("d_ready", 32'(d_ready), 32'h1);
        chk("d_err", 32'(d_err), 32'h0);
        chk("d_i_ready", 32'(i_ready), 32'h0);
        cyc();
        d_req = 1'b0; d_wen = 1'b0; m_ready = 1'b0;
        settle();
        chk("d_done_m_req", 32'(m_req), 32'h0);
        chk("d_hold_addr", m_addr, 32'h8000_1000);

        // Contention from reset: expected order I, D, I, D
        rst = 1'b0;
        settle();
        chk("rr_rst_m_req", 32'(m_req), 32'h0);
        cyc();
        rst = 1'b1;
        i_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
        i_req = 1'b1; d_req = 1'b1;
        settle();
        for (int t = 0; t < 4; t++) begin
            cyc();
            if (t > 0) begin
                if (exp_side[t-1]) d_req = 1'b1;
                else               i_req = 1'b1;
            end
            settle();
            chk("rr_m_req", 32'(m_req), 32'h1);
            chk("rr_addr", m_addr, (exp_side[t] ? 32'h0000_0200 : 32'h0000_0100));
            m_ready = 1'b1; m_rdata = 32'(t + 1);
            settle();
            chk("rr_i_ready", 32'(i_ready), 32'(!exp_side[t]));
            chk("rr_d_ready", 32'(d_ready), 32'(exp_side[t]));
            if (exp_side[t]) chk("rr_d_rdata", d_rdata, 32'(t + 1));
            else             chk("rr_i_rdata", i_rdata, 32'(t + 1));
            cyc();
            m_ready = 1'b0;
            if (exp_side[t]) d_req = 1'b0;
            else             i_req = 1'b0;
            settle();
            chk("rr_idle", 32'(m_req), 32'h0);
        end
        i_req = 1'b0; d_req = 1'b0;
        settle();

        // Timeout: no m_ready, abort on the 8th grant cycle
        d_addr = 32'h0000_0300; d_req = 1'b1; m_rdata = 32'h0000_1234;
        settle();
        for (int g = 1; g < 8; g++) begin
            cyc(); settle();
            chk("to_no_ready", 32'(d_ready), 32'h0);
        end
        cyc(); settle();
        chk("to_d_ready", 32'(d_ready), 32'h1);
        chk("to_d_err", 32'(d_err), 32'h1);
        chk("to_d_rdata", d_rdata, 32'h0);
        chk("to_i_ready", 32'(i_ready), 32'h0);
        cyc();
        d_req = 1'b0;
        settle();
        chk("to_m_req", 32'(m_req), 32'h0);
        m_ready = 1'b1;
        settle();
        chk("to_late_d", 32'(d_ready), 32'h0);
        chk("to_late_i", 32'(i_ready), 32'h0);
        chk("to_late_err", 32'(d_err), 32'h0);
        cyc();
        m_ready = 1'b0;
        settle();

        // m_ready on the timeout cycle is a normal completion
        d_addr = 32'h0000_0400; d_req = 1'b1;
        settle();
        for (int g = 1; g < 8; g++) cyc();
        cyc();
        m_ready = 1'b1; m_rdata = 32'hCAFE_F00D;
        settle();
        chk("edge_d_ready", 32'(d_ready), 32'h1);
        chk("edge_d_err", 32'(d_err), 32'h0);
        chk("edge_d_rdata", d_rdata, 32'hCAFE_F00D);
        cyc();
        d_req = 1'b0; m_ready = 1'b0;
        settle();
        chk("edge_m_req", 32'(m_req), 32'h0);

        // Reset mid-grant drops m_req without a clock edge
        i_addr = 32'h0000_0500; i_req = 1'b1;
        settle();
        cyc(); settle();
        chk("mr_m_req", 32'(m_req), 32'h1);
        d_addr = 32'h0000_0600; d_req = 1'b1;
        settle();
        rst = 1'b0;
        settle();
        chk("mr_async_m_req", 32'(m_req), 32'h0);
        chk("mr_i_ready", 32'(i_ready), 32'h0);
        i_req = 1'b0;
        cyc();
        rst = 1'b1;
        settle();
        chk("mr_release_m_req", 32'(m_req), 32'h0);
        cyc(); settle();
        chk("mr_d_grant", 32'(m_req), 32'h1);
        chk("mr_d_addr", m_addr, 32'h0000_0600);
        m_ready = 1'b1; m_rdata = 32'h0000_0777;
        settle();
        chk("mr_d_ready", 32'(d_ready), 32'h1);
        chk("mr_i_quiet", 32'(i_ready), 32'h0);
        cyc();
        d_req = 1'b0; m_ready = 1'b0;
        settle();
        chk("mr_done", 32'(m_req), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
